// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler that shares one external combinational ALU
// between two requesters.
//
// Each requester offers an operation over a valid/ready handshake. When both are
// valid, the requester that was not granted last time wins. An accepted
// operation is registered onto the ALU inputs and executes for one cycle. The
// ALU result is then captured and held on the result channel, tagged with the
// issuing requester, until the consumer takes it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rN_valid / rN_ready       requester N handshake (N = 0, 1)
//   rN_a, rN_b, rN_inst, rN_sel  requester N operands, opcode and select bit
//   alu_a, alu_b, alu_inst, alu_sel  registered inputs to the shared ALU
//   alu_z                     ALU output, combinational from alu_*
//   res_valid / res_ready     result channel handshake
//   res_data, res_id          captured ALU result and the id of its requester
//   busy                      an operation is executing or its result is pending
module alu_rr_sched #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IW    = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [IW-1:0]    r0_inst,
    input  logic             r0_sel,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [IW-1:0]    r1_inst,
    input  logic             r1_sel,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [IW-1:0]    alu_inst,
    output logic             alu_sel,
    input  logic [WIDTH-1:0] alu_z,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,

    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               op_id_q, op_id_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [IW-1:0]      alu_inst_q, alu_inst_d;
    logic               alu_sel_q, alu_sel_d;
    logic               res_valid_q, res_valid_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_id_q, res_id_d;

    logic               can_accept;
    logic               grant;
    logic               accept;

    // Grant: a lone valid wins outright; on a tie the requester not served last wins.
    // Reset suppresses any handshake so nothing is accepted while it is asserted.
    always_comb begin
        can_accept = (state_q == StIdle) || ((state_q == StDone) && res_ready);
        if (r0_valid && r1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = r1_valid;
        end
        accept   = can_accept && (r0_valid || r1_valid) && !rst;
        r0_ready = accept && !grant;
        r1_ready = accept && grant;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_id_d      = op_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_inst_d   = alu_inst_q;
        alu_sel_d    = alu_sel_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;

        // Operand load is shared by the IDLE accept and the DONE retire-and-accept.
        if (accept) begin
            alu_a_d      = grant ? r1_a    : r0_a;
            alu_b_d      = grant ? r1_b    : r0_b;
            alu_inst_d   = grant ? r1_inst : r0_inst;
            alu_sel_d    = grant ? r1_sel  : r0_sel;
            op_id_d      = grant;
            last_grant_d = grant;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                res_data_d  = alu_z;
                res_id_d    = op_id_q;
                res_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = accept ? StExec : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            op_id_q      <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_inst_q   <= '0;
            alu_sel_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_id_q      <= op_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_inst_q   <= alu_inst_d;
            alu_sel_q    <= alu_sel_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_inst  = alu_inst_q;
    assign alu_sel   = alu_sel_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q == StExec) || (state_q == StDone);

endmodule
